// File: rtl/mawg_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mawg_cfg_pkg
// Description : Shared definitions for the waveform generator configuration
//               path: decoder state encoding, default clear command and the
//               register index map used by the waveform generator.
// Revision    : 1.0 - initial release
// ============================================================================
package mawg_cfg_pkg;

   // Frame decoder states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CKSUM = 2'd2
   } cfg_state_t;

   // Command byte that zeroes the whole bank
   localparam logic [7:0] C_CLEAR_CMD_DEFAULT = 8'hFF;

   // Register index map
   localparam logic [7:0] C_CMD_OUT_SEL     = 8'd0;
   localparam logic [7:0] C_CMD_WAVE_SEL    = 8'd1;
   localparam logic [7:0] C_CMD_FREQ        = 8'd2;
   localparam logic [7:0] C_CMD_CHIRP_DIR   = 8'd3;
   localparam logic [7:0] C_CMD_CHIRP_DELAY = 8'd4;
   localparam logic [7:0] C_CMD_CHIRP_MIN   = 8'd5;
   localparam logic [7:0] C_CMD_CHIRP_MAX   = 8'd6;
   localparam logic [7:0] C_CMD_CHIRP_DIV   = 8'd7;
   localparam logic [7:0] C_CMD_CHIRP_INC   = 8'd8;
   localparam logic [7:0] C_CMD_DUTY        = 8'd9;
   localparam logic [7:0] C_CMD_FM_CTR      = 8'd10;
   localparam logic [7:0] C_CMD_FM_DEV      = 8'd11;
   localparam logic [7:0] C_CMD_FM_DEMOD    = 8'd12;

endpackage
`default_nettype wire

// File: rtl/byte_strobe.sv
`default_nettype none
// ============================================================================
// Module      : byte_strobe
// Description : Falling-edge detector on the UART receiver busy flag. The
//               accept pulse is combinational so the byte is sampled at the
//               same edge that sees the fall.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_strobe (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   output logic accept
);

   logic r_busy_q;

   // Delayed copy of busy; reset to 0 so a high busy at reset release never
   // produces a phantom accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy_q <= 1'b0;
      else        r_busy_q <= busy;
   end

   assign accept = r_busy_q & ~busy;

endmodule
`default_nettype wire

// File: rtl/uart_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_regbank
// Description : Decodes checksummed write frames from the UART byte stream
//               into a bank of NUM_REGS registers of REG_BYTES bytes each,
//               with inter-byte timeout, address checking and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_regbank
   import mawg_cfg_pkg::*;
#(
   parameter int         NUM_REGS       = 16,
   parameter int         REG_BYTES      = 4,
   parameter int         TIMEOUT_CYCLES = 2000,
   parameter logic [7:0] CLEAR_CMD      = C_CLEAR_CMD_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            rx_busy,
   input  logic [7:0]                      rx_data,
   output logic [NUM_REGS*8*REG_BYTES-1:0] regs,
   output logic                            wr_stb,
   output logic [7:0]                      wr_addr,
   output logic                            err_cksum,
   output logic                            err_addr,
   output logic                            err_timeout
);

   localparam int W     = 8 * REG_BYTES;
   localparam int CNT_W = $clog2(REG_BYTES) + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REG_BYTES - 1);
   localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   cfg_state_t       r_state;
   cfg_state_t       w_state_next;
   logic             w_accept;
   logic [7:0]       r_cmd;
   logic [7:0]       r_acc;
   logic [W-1:0]     r_shift;
   logic [W-1:0]     w_shift_next;
   logic [CNT_W-1:0] r_cnt;
   logic [TMR_W-1:0] r_tmr;
   logic             w_resolve;
   logic             w_cksum_bad;
   logic             w_clear;
   logic             w_addr_bad;
   logic             w_write;
   logic             w_timeout;

   byte_strobe u_byte_strobe (
      .clk    (clk),
      .rst_n  (rst_n),
      .busy   (rx_busy),
      .accept (w_accept)
   );

   // Data bytes arrive MSB first, so each new byte enters at the bottom
   if (REG_BYTES == 1) begin : g_shift_single
      assign w_shift_next = rx_data;
   end else begin : g_shift_multi
      assign w_shift_next = {r_shift[W-9:0], rx_data};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; an accept always takes priority over a timeout
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = ST_DATA;
         end
         ST_DATA: begin
            if (w_accept) begin
               if (r_cnt == C_CNT_LAST) w_state_next = ST_CKSUM;
            end else if (w_timeout) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_CKSUM: begin
            if (w_accept || w_timeout) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Frame resolution and timeout decode, in checksum > clear > address order
   always_comb begin
      w_resolve   = w_accept && (r_state == ST_CKSUM);
      w_cksum_bad = w_resolve && (rx_data != r_acc);
      w_clear     = w_resolve && !w_cksum_bad && (r_cmd == CLEAR_CMD);
      w_addr_bad  = w_resolve && !w_cksum_bad && !w_clear &&
                    ({24'd0, r_cmd} >= 32'(NUM_REGS));
      w_write     = w_resolve && !w_cksum_bad && !w_clear && !w_addr_bad;
      w_timeout   = (r_state != ST_IDLE) && !w_accept && (r_tmr == C_TMR_LAST);
   end

   // Frame datapath: command latch, checksum accumulator, byte counter, timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd   <= 8'd0;
         r_acc   <= 8'd0;
         r_shift <= '0;
         r_cnt   <= '0;
         r_tmr   <= '0;
      end else begin
         if (w_accept) begin
            if (r_state == ST_IDLE) begin
               r_cmd <= rx_data;
               r_acc <= rx_data;
               r_cnt <= '0;
            end else if (r_state == ST_DATA) begin
               r_shift <= w_shift_next;
               r_acc   <= r_acc ^ rx_data;
               r_cnt   <= r_cnt + 1'b1;
            end
         end
         if (w_accept || (r_state == ST_IDLE) || w_timeout) r_tmr <= '0;
         else                                              r_tmr <= r_tmr + 1'b1;
      end
   end

   // Registered strobes and last committed address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_stb      <= 1'b0;
         wr_addr     <= 8'd0;
         err_cksum   <= 1'b0;
         err_addr    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         wr_stb      <= w_write || w_clear;
         err_cksum   <= w_cksum_bad;
         err_addr    <= w_addr_bad;
         err_timeout <= w_timeout;
         if (w_write || w_clear) wr_addr <= r_cmd;
      end
   end

   // Register array, one slice per index
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [W-1:0] r_reg;

      // Clear wins over a write; only the addressed register loads
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                 r_reg <= '0;
         else if (w_clear)                           r_reg <= '0;
         else if (w_write && (r_cmd == 8'(gi)))      r_reg <= r_shift;
      end

      assign regs[gi*W +: W] = r_reg;
   end

endmodule
`default_nettype wire

// File: doc/uart_cfg_regbank.md
# uart_cfg_regbank

Parametrised configuration register bank fed by the UART receiver's byte stream. It decodes framed write commands into a bank of `NUM_REGS` registers, each `REG_BYTES` bytes wide, and drives them as a flat vector to the waveform generator and other consumers. Compared with the earlier fixed decoder it adds:
- an XOR checksum per frame;
- an inter-byte timeout that resynchronises a stalled frame;
- address range checking;
- write and error strobes;
- a defined power-up state.

## Interface
Parameters:
- `NUM_REGS`, 16, number of registers (1..255).
- `REG_BYTES`, 4, bytes per register (1..4); register width `W = 8*REG_BYTES`.
- `TIMEOUT_CYCLES`, 2000, idle clocks allowed between bytes of one frame (≥2).
- `CLEAR_CMD`, 8'hFF, command byte that zeroes every register; must be ≥ `NUM_REGS`.

Ports:
- `clk` input 1: single clock; every flop is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx_busy` input 1: UART receiver busy flag, synchronous to `clk`.
- `rx_data` input 8: received byte, valid when `rx_busy` falls.
- `regs` output `NUM_REGS*W`: flat register bank; register i occupies bits `[i*W +: W]`.
- `wr_stb` output 1: one-cycle pulse when a register write or a clear commits.
- `wr_addr` output 8: command byte of the last committed frame; holds its value between commits.
- `err_cksum` output 1: one-cycle pulse when a frame is dropped for a bad checksum.
- `err_addr` output 1: one-cycle pulse when a frame is dropped for a bad address.
- `err_timeout` output 1: one-cycle pulse when a partial frame is abandoned on timeout.

## Operation
- **Byte accept.**
  - `busy_q` is a registered copy of `rx_busy`; its reset value is 0.
  - A byte is accepted at a clock edge where `busy_q`=1 and `rx_busy`=0, and `rx_data` is sampled at that same edge.
- **Frame format:** `cmd`, then `REG_BYTES` data bytes MSB first, then `ck`.
  - A frame is valid when `ck` equals the XOR of `cmd` and all data bytes.
- **States.**
  - IDLE: an accepted byte is latched as `cmd`; `acc`←byte; `cnt`←0; go to DATA.
  - DATA: an accepted byte is shifted into `shift` (`{shift[W-9:0], byte}`); `acc`^=byte; `cnt`++.
    - Go to CKSUM when `cnt` reaches `REG_BYTES-1` at that accept.
  - CKSUM: an accepted byte is compared with `acc`, and the frame is resolved in this priority order:
    1. Mismatch: pulse `err_cksum`; no write.
    2. `cmd`==`CLEAR_CMD`: all registers ←0; pulse `wr_stb`; `wr_addr`←`cmd`.
    3. `cmd`≥`NUM_REGS`: pulse `err_addr`; no write.
    4. Otherwise: `regs[cmd]`←`shift`; pulse `wr_stb`; `wr_addr`←`cmd`.
    - The state always returns to IDLE.
- **Timeout.**
  - `tmr` clears on every accept and in IDLE; it increments on every other clock in DATA or CKSUM.
  - When `tmr`==`TIMEOUT_CYCLES-1` and no accept occurs that edge: go to IDLE, pulse `err_timeout`, discard the partial frame.
  - If an accept and the timeout coincide, the accept wins.
- A clear frame still carries `REG_BYTES` data bytes; their values are ignored, but they are included in the checksum.
- Registers not addressed by a frame never change.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - `regs`=0, `wr_addr`=0, all strobes 0, state IDLE, `busy_q`=0, `tmr`=0, `cnt`=0.
  - Because `busy_q` resets to 0, no spurious accept can occur when `rx_busy` is high at reset release.
  - Reset mid-frame discards the frame.
- **Commit latency:** zero.
  - `regs`, `wr_stb`, `wr_addr` and the error strobes update at the same edge that accepts the checksum byte.
  - They are visible in the following cycle; each strobe is high for exactly one cycle.
- **Back-to-back bytes:** accepts can occur on any edge, with at most one accept per falling edge of `rx_busy`. A new frame's `cmd` may be accepted on the cycle after a commit.
- **Counter widths:** `cnt` is `clog2(REG_BYTES)+1` bits; `tmr` is `clog2(TIMEOUT_CYCLES)` bits and saturates by construction (the timeout forces IDLE).

## Structure
- **Shared package `mawg_cfg_pkg`:**
  - state enum (IDLE, DATA, CKSUM);
  - default `CLEAR_CMD`;
  - command index constants: OUT_SEL=0, WAVE_SEL=1, FREQ=2, CHIRP_DIR=3, CHIRP_DELAY=4, CHIRP_MIN=5, CHIRP_MAX=6, CHIRP_DIV=7, CHIRP_INC=8, DUTY=9, FM_CTR=10, FM_DEV=11, FM_DEMOD=12.
- **One sub-module:** `byte_strobe`, the `rx_busy` falling-edge detector that outputs an accept pulse. It is reusable by other UART consumers.
- Everything else is flat: the FSM, the accumulator, the timer and the register array.

## Test plan
Parameters for the bench: `NUM_REGS`=16, `REG_BYTES`=4, `TIMEOUT_CYCLES`=100, `CLEAR_CMD`=FF.
- Frame 02 12 34 56 78 0A → `regs[2]`=0x12345678; one `wr_stb`; `wr_addr`=02; all other registers stay 0.
- Same frame with checksum 0B → `err_cksum` pulses once; `regs[2]` is unchanged; no `wr_stb`.
- Frame 20 12 34 56 78 28 → `err_addr` pulses once; no register changes.
- After writing registers 2 and 5, frame FF 12 34 56 78 F7 → all registers are 0; `wr_stb`; `wr_addr`=FF.
- Send bytes 02 12, then hold `rx_busy` low for 100 cycles → `err_timeout` pulses once. A following frame 05 00 00 00 2A 2F writes `regs[5]`=0x2A.
- Send bytes 02 12 34, pulse `rst_n` low, then send 03 00 00 00 07 04 → `regs[3]`=7, `regs[2]`=0, and no errors are flagged.
